// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer writer: default geometry, FSM
// state encoding and the RGB888 to framebuffer colour-depth reduction.
package fb_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_ADDR_W = 15;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } fb_state_t;

    // Keeps the top bits of each channel; callers truncate to their depth.
    function automatic logic [23:0] rgb_to_fb(input logic [23:0] rgb24,
                                              input int          colour_bits);
        case (colour_bits)
            3:       return {21'd0, rgb24[23], rgb24[15], rgb24[7]};
            9:       return {15'd0, rgb24[23:21], rgb24[15:13], rgb24[7:5]};
            default: return rgb24;
        endcase
    endfunction

endpackage

// File: rtl/framebuffer_writer_fifo.sv
// Small synchronous FIFO holding pending {address, colour} pixel writes.
// Flush wins over push and pop; the head entry is read combinationally.
module pixel_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Draw-bus receiver: buffers pixel strobes, converts and linearises them into
// framebuffer writes, and sweeps the whole framebuffer on a clear request.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int WIDTH       = FB_WIDTH,
    parameter int HEIGHT      = FB_HEIGHT,
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int COLOUR_BITS = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   draw_enable,
    input  logic [7:0]             x_in,
    input  logic [7:0]             y_in,
    input  logic [23:0]            rgb_in,
    input  logic                   clear_req,
    input  logic [23:0]            clear_rgb,
    output logic                   fb_we,
    output logic [ADDR_W-1:0]      fb_addr,
    output logic [COLOUR_BITS-1:0] fb_data,
    output logic                   busy,
    output logic                   overflow,
    output logic                   out_of_bounds
);
    localparam int PIX_LAST = WIDTH * HEIGHT - 1;
    localparam int DW       = ADDR_W + COLOUR_BITS;

    fb_state_t              r_state;
    fb_state_t              w_state_nxt;
    logic [ADDR_W-1:0]      r_cnt;
    logic [COLOUR_BITS-1:0] r_clear_col;
    logic                   r_fb_we;
    logic [ADDR_W-1:0]      r_fb_addr;
    logic [COLOUR_BITS-1:0] r_fb_data;
    logic                   r_overflow;
    logic                   r_oob;

    logic                   w_in_bounds;
    logic [ADDR_W-1:0]      w_addr;
    logic [COLOUR_BITS-1:0] w_colour;
    logic                   w_full;
    logic                   w_empty;
    logic [DW-1:0]          w_rdata;
    logic                   w_draw_ok;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_flush;
    logic                   w_clear_go;

    assign w_in_bounds = (int'(x_in) < WIDTH) && (int'(y_in) < HEIGHT);
    assign w_addr      = ADDR_W'(int'(y_in) * WIDTH + int'(x_in));
    assign w_colour    = COLOUR_BITS'(rgb_to_fb(rgb_in, COLOUR_BITS));
    // Full is the pre-pop status, so a push into a full FIFO is refused even
    // when an entry leaves on the same edge.
    assign w_draw_ok   = draw_enable && w_in_bounds && !w_full;

    pixel_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata ({w_addr, w_colour}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_clear_go  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_clear_go  = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_push = w_draw_ok;
                    w_pop  = !w_empty;
                end
            end
            S_CLEAR: begin
                w_push = w_draw_ok;
                if (r_cnt == ADDR_W'(PIX_LAST)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_clear_col <= '0;
            r_fb_we     <= 1'b0;
            r_fb_addr   <= '0;
            r_fb_data   <= '0;
            r_overflow  <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            r_fb_we <= 1'b0;
            if (r_state == S_CLEAR) begin
                r_fb_we   <= 1'b1;
                r_fb_addr <= r_cnt;
                r_fb_data <= r_clear_col;
                r_cnt     <= r_cnt + 1'b1;
            end else if (w_pop) begin
                r_fb_we                <= 1'b1;
                {r_fb_addr, r_fb_data} <= w_rdata;
            end
            // A strobe coinciding with clear acceptance is dropped silently.
            if (w_clear_go) begin
                r_cnt       <= '0;
                r_clear_col <= COLOUR_BITS'(rgb_to_fb(clear_rgb, COLOUR_BITS));
                r_overflow  <= 1'b0;
                r_oob       <= 1'b0;
            end else if (draw_enable) begin
                if (!w_in_bounds) r_oob      <= 1'b1;
                else if (w_full)  r_overflow <= 1'b1;
            end
        end
    end

    assign fb_we         = r_fb_we;
    assign fb_addr       = r_fb_addr;
    assign fb_data       = r_fb_data;
    assign overflow      = r_overflow;
    assign out_of_bounds = r_oob;
    assign busy          = (r_state == S_CLEAR) || !w_empty || r_fb_we;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: expected writes are queued as pixels
// are driven and compared in order as the DUT raises fb_we.
module tb_framebuffer_writer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        draw_enable = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic [23:0] rgb_in = '0;
    logic        clear_req = 1'b0;
    logic [23:0] clear_rgb = '0;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy;
    logic        overflow;
    logic        out_of_bounds;

    int total  = 0;
    int passed = 0;
    int exp_a[$];
    int exp_d[$];

    framebuffer_writer #(
        .WIDTH       (160),
        .HEIGHT      (120),
        .ADDR_W      (15),
        .COLOUR_BITS (3),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .draw_enable   (draw_enable),
        .x_in          (x_in),
        .y_in          (y_in),
        .rgb_in        (rgb_in),
        .clear_req     (clear_req),
        .clear_rgb     (clear_rgb),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .busy          (busy),
        .overflow      (overflow),
        .out_of_bounds (out_of_bounds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int col3(input logic [23:0] rgb);
        return {29'd0, rgb[23], rgb[15], rgb[7]};
    endfunction

    task automatic expect_px(input int x, input int y, input logic [23:0] rgb);
        exp_a.push_back(y * 160 + x);
        exp_d.push_back(col3(rgb));
    endtask

    task automatic strobe(input int x, input int y, input logic [23:0] rgb);
        draw_enable = 1'b1;
        x_in        = 8'(x);
        y_in        = 8'(y);
        rgb_in      = rgb;
        @(posedge clk);
        #1;
        draw_enable = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_a.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check({"drain_", tag}, 32'(exp_a.size()), 32'd0);
    endtask

    // Scoreboard: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && fb_we) begin
            check("we_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) begin
                int ea;
                int ed;
                ea = exp_a.pop_front();
                ed = exp_d.pop_front();
                check("fb_addr", 32'(fb_addr), 32'(ea));
                check("fb_data", 32'(fb_data), 32'(ed));
            end
        end
    end

    initial begin
        int cyc;
        int we_hi;
        int busy_lo;
        int k;
        logic [23:0] rgbtab [5];
        rgbtab[0] = 24'hFF0000;
        rgbtab[1] = 24'h00FF00;
        rgbtab[2] = 24'h0000FF;
        rgbtab[3] = 24'hFFFFFF;
        rgbtab[4] = 24'h123456;

        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_data", 32'(fb_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_oob", 32'(out_of_bounds), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel: (5,2) magenta -> addr 325, colour 3'b101.
        expect_px(5, 2, 24'hFF00FF);
        strobe(5, 2, 24'hFF00FF);
        check("single_busy_pending", 32'(busy), 32'd1);
        wait_drain("single", 20);
        @(posedge clk);
        #1;
        check("single_busy_low", 32'(busy), 32'd0);

        // Burst of six back-to-back strobes drains without overflow.
        for (int i = 0; i < 6; i++) begin
            expect_px(i, 0, 24'h00FFFF);
            draw_enable = 1'b1;
            x_in        = 8'(i);
            y_in        = 8'd0;
            rgb_in      = 24'h00FFFF;
            @(posedge clk);
            #1;
        end
        draw_enable = 1'b0;
        wait_drain("burst", 20);
        check("burst_ovf", 32'(overflow), 32'd0);
        check("pre_oob", 32'(out_of_bounds), 32'd0);

        // Bounds: both off-screen pixels discarded, corner pixel written.
        strobe(160, 0, 24'hFFFFFF);
        check("oob_x", 32'(out_of_bounds), 32'd1);
        strobe(0, 120, 24'hFFFFFF);
        check("oob_y", 32'(out_of_bounds), 32'd1);
        expect_px(159, 119, 24'h0000FF);
        strobe(159, 119, 24'h0000FF);
        wait_drain("corner", 20);

        // Pending pixel A is flushed by the clear; the off-screen strobe
        // coinciding with acceptance must not set any flag.
        draw_enable = 1'b1;
        x_in        = 8'd10;
        y_in        = 8'd10;
        rgb_in      = 24'hFFFFFF;
        @(posedge clk);
        #1;
        x_in      = 8'd200;
        y_in      = 8'd0;
        clear_req = 1'b1;
        clear_rgb = 24'h00FF00;
        for (int i = 0; i < 19200; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(2);
        end
        @(posedge clk);
        #1;
        draw_enable = 1'b0;
        clear_req   = 1'b0;
        check("clr_oob_cleared", 32'(out_of_bounds), 32'd0);
        check("clr_ovf_cleared", 32'(overflow), 32'd0);
        check("clr_busy", 32'(busy), 32'd1);

        cyc     = 0;
        we_hi   = 0;
        busy_lo = 0;
        while (exp_a.size() != 0 && cyc < 20000) begin
            @(negedge clk);
            #1;
            cyc++;
            if (fb_we) we_hi++;
            if (!busy) busy_lo++;
            if (cyc >= 100 && cyc < 105) begin
                k           = cyc - 100;
                draw_enable = 1'b1;
                x_in        = 8'(20 + k);
                y_in        = 8'd7;
                rgb_in      = rgbtab[k];
                if (k < 4) expect_px(20 + k, 7, rgbtab[k]);
            end else begin
                draw_enable = 1'b0;
            end
        end
        draw_enable = 1'b0;
        check("clr_drain", 32'(exp_a.size()), 32'd0);
        check("clr_cycles", 32'(cyc), 32'd19205);
        check("clr_we_count", 32'(we_hi), 32'd19204);
        check("clr_busy_low", 32'(busy_lo), 32'd0);
        check("clr_ovf_set", 32'(overflow), 32'd1);
        check("clr_oob_still0", 32'(out_of_bounds), 32'd0);
        @(posedge clk);
        #1;
        check("clr_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a second sweep.
        clear_req = 1'b1;
        clear_rgb = 24'hFF0000;
        for (int i = 0; i < 1500; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(4);
        end
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        cyc = 0;
        while (!(fb_we && fb_addr == 15'd1000) && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("rst_mid_reached", 32'(fb_addr), 32'd1000);
        resetn = 1'b0;
        #1;
        check("rst_mid_we", 32'(fb_we), 32'd0);
        check("rst_mid_addr", 32'(fb_addr), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        exp_a.delete();
        exp_d.delete();
        #2;
        resetn = 1'b1;
        we_hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (fb_we) we_hi++;
        end
        check("post_rst_writes", 32'(we_hi), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
Receiving end of the pixel draw bus driven by the tile drawers: vga_draw_enable_bus, vga_x_out_bus, vga_y_out_bus and vga_RGB_out_bus.
- Captures each one-cycle draw strobe into a small FIFO.
- Converts 24-bit RGB to the framebuffer colour depth and linearises (x,y) into a framebuffer address.
- Issues single-cycle writes to the framebuffer RAM port of the VGA adapter.
- Also provides a full-screen clear sequence that sweeps every address.

Parameters:
WIDTH, 160, visible pixels per row.
HEIGHT, 120, visible rows.
ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
COLOUR_BITS, 3, framebuffer colour depth. Legal values: 3, 9, 24.
FIFO_DEPTH, 4, pixel FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
draw_enable  in  1  one-cycle pixel strobe from the draw bus.
x_in  in  8  pixel x from the draw bus.
y_in  in  8  pixel y from the draw bus.
rgb_in  in  24  {R,G,B}, 8 bits each.
clear_req  in  1  level request to clear the screen.
clear_rgb  in  24  clear colour, sampled when a clear is accepted.
fb_we  out  1  framebuffer write enable, one cycle per pixel.
fb_addr  out  ADDR_W  framebuffer address.
fb_data  out  COLOUR_BITS  framebuffer pixel data.
busy  out  1  high while clearing or while the FIFO is non-empty.
overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
out_of_bounds  out  1  sticky: a pixel with x>=WIDTH or y>=HEIGHT was discarded.

Behaviour:
- Reset (resetn low, asynchronous): FIFO empty, FSM to S_IDLE, all outputs 0. Reset mid-clear abandons the sweep with no further writes.
- Input acceptance: on a clk edge with draw_enable=1:
  - Pixel in bounds and FIFO not full: enqueue {addr, colour}.
  - Out of bounds: not enqueued; out_of_bounds set.
  - FIFO full: not enqueued; overflow set.
  - Both sticky flags clear only on reset or on an accepted clear.
- Address: addr = y*WIDTH + x, computed at enqueue in ADDR_W bits. No wrap; bounds are checked first.
- Colour conversion:
  - COLOUR_BITS=3: {R[7],G[7],B[7]}.
  - COLOUR_BITS=9: {R[7:5],G[7:5],B[7:5]}.
  - COLOUR_BITS=24: passthrough.
- FSM S_IDLE:
  - clear_req=1 has priority over draining: accept the clear, flush the FIFO, capture the converted clear_rgb, set the counter to 0, go to S_CLEAR. A draw_enable in the same cycle is dropped without setting any flag.
  - Otherwise, if the FIFO is non-empty, pop one entry; fb_we=1 with its addr/data on the next cycle.
  - Drain rate is one pixel per cycle.
- FSM S_CLEAR:
  - Each cycle: fb_we=1, fb_addr=counter, fb_data=clear colour, counter++.
  - After address WIDTH*HEIGHT-1 is written, return to S_IDLE. Total exactly WIDTH*HEIGHT writes.
  - draw_enable is still accepted into the FIFO (flags apply) and drained after the clear. clear_req is ignored during S_CLEAR.
- Latency: with the FIFO empty and in S_IDLE, draw_enable at edge N gives fb_we high during cycle N+1..N+2, i.e. one cycle after the pixel is visible in the FIFO.
- Simultaneous push and pop on a full FIFO: the push is still rejected (overflow set). The full flag is evaluated before the pop.
- fb_addr and fb_data are registered outputs and hold their last value when fb_we=0.
- busy = (state==S_CLEAR) | FIFO non-empty | fb_we.

Decomposition:
- Shared package fb_pkg: WIDTH, HEIGHT, ADDR_W defaults; state encoding S_IDLE/S_CLEAR; function rgb_to_fb(rgb24, COLOUR_BITS).
- One sub-module: pixel_fifo (synchronous FIFO with push/pop/full/empty/flush, data width ADDR_W+COLOUR_BITS, depth FIFO_DEPTH, async active-low reset).

Test Plan:
- Single pixel: reset, then draw_enable for one cycle with x=5, y=2, rgb=24'hFF00FF (COLOUR_BITS=3) -> exactly one fb_we pulse with fb_addr=325 and fb_data=3'b101; busy then falls to 0.
- Burst: 6 consecutive strobes at (0,0)..(5,0) with FIFO_DEPTH=4 -> the first strobe is popped while the next arrive, so the FIFO never fills. Expect 6 writes at addresses 0..5 in order and overflow=0. Then pre-load with clear active and send 5 strobes -> 4 kept, overflow=1.
- Bounds: x=160,y=0 and x=0,y=120 -> no fb_we and out_of_bounds=1. x=159,y=119 -> fb_addr=19199.
- Clear: clear_req with clear_rgb=24'h00FF00 -> 19200 consecutive fb_we cycles with addresses 0..19199 and data 3'b010. Flags are cleared, and busy is high throughout.
- Clear versus draw: pixels pending in the FIFO when clear_req is accepted are never written. A pixel strobed mid-clear is written once, after address 19199.
- Async reset mid-clear at counter=1000 -> fb_we=0 immediately without waiting for a clock. After release, the FSM is in S_IDLE and no further writes occur.
